// File: rtl/runway_scheduler.sv
// runway_scheduler: two-queue runway arbiter with landing priority and weather gating.
// Define RUNWAY_FAIRNESS_EN to let a takeoff through after three landings it waited behind.
module runway_scheduler #(
    parameter int QDEPTH     = 4,
    parameter int OCC_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       land_req,
    input  logic [3:0] land_id,
    input  logic       takeoff_req,
    input  logic [3:0] takeoff_id,
    input  logic       severe_weather,
    input  logic       emergency_landing_alert,
    output logic       grant_valid,
    output logic [3:0] grant_id,
    output logic       grant_is_land,
    output logic       runway_busy,
    output logic [3:0] land_count,
    output logic [3:0] takeoff_count,
    output logic       land_drop,
    output logic       takeoff_drop,
    output logic [1:0] sched_state
);
    localparam int PW = $clog2(QDEPTH);
    localparam logic [3:0] QD = 4'(QDEPTH);
    localparam logic [3:0] OCC_LAST = 4'(OCC_CYCLES - 1);

    typedef enum logic [1:0] {IDLE = 2'b00, LAND = 2'b01, TAKEOFF = 2'b10, GAP = 2'b11} state_t;

    state_t        state;
    logic [3:0]    land_mem [QDEPTH];
    logic [3:0]    tk_mem [QDEPTH];
    logic [PW-1:0] land_wp, land_rp, tk_wp, tk_rp;
    logic [3:0]    occ;
    logic          tk_ok, fair_pick, land_pop, tk_pop, land_push, tk_push;

`ifdef RUNWAY_FAIRNESS_EN
    logic [1:0] fair_cnt;

    // Counts landings that jumped a waiting takeoff; cleared by any takeoff.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            fair_cnt <= 2'd0;
        else if (tk_pop)
            fair_cnt <= 2'd0;
        else if (land_pop && takeoff_count != 4'd0 && fair_cnt != 2'd3)
            fair_cnt <= fair_cnt + 2'd1;
    end

    // tk_ok already excludes emergency_landing_alert, which suppresses the override.
    assign fair_pick = fair_cnt == 2'd3 && tk_ok;
`else
    assign fair_pick = 1'b0;
`endif

    always_comb begin
        tk_ok     = takeoff_count != 4'd0 && !severe_weather && !emergency_landing_alert;
        land_pop  = state == IDLE && land_count != 4'd0 && !fair_pick;
        tk_pop    = state == IDLE && tk_ok && (land_count == 4'd0 || fair_pick);
        land_push = land_req && (land_count < QD || land_pop);
        tk_push   = takeoff_req && (takeoff_count < QD || tk_pop);
    end

    always_ff @(posedge CLK) begin
        if (land_push) land_mem[land_wp] <= land_id;
        if (tk_push) tk_mem[tk_wp] <= takeoff_id;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= IDLE;
            occ           <= 4'd0;
            grant_valid   <= 1'b0;
            grant_id      <= 4'd0;
            grant_is_land <= 1'b0;
            land_drop     <= 1'b0;
            takeoff_drop  <= 1'b0;
            land_count    <= 4'd0;
            takeoff_count <= 4'd0;
            land_wp       <= '0;
            land_rp       <= '0;
            tk_wp         <= '0;
            tk_rp         <= '0;
        end else begin
            grant_valid   <= land_pop || tk_pop;
            land_drop     <= land_req && !land_push;
            takeoff_drop  <= takeoff_req && !tk_push;
            land_count    <= land_count + {3'b0, land_push} - {3'b0, land_pop};
            takeoff_count <= takeoff_count + {3'b0, tk_push} - {3'b0, tk_pop};
            if (land_push) land_wp <= land_wp + 1'b1;
            if (land_pop) land_rp <= land_rp + 1'b1;
            if (tk_push) tk_wp <= tk_wp + 1'b1;
            if (tk_pop) tk_rp <= tk_rp + 1'b1;
            case (state)
                IDLE: begin
                    if (land_pop || tk_pop) begin
                        state         <= land_pop ? LAND : TAKEOFF;
                        grant_id      <= land_pop ? land_mem[land_rp] : tk_mem[tk_rp];
                        grant_is_land <= land_pop;
                        occ           <= OCC_LAST;
                    end
                end
                LAND, TAKEOFF: begin
                    if (occ == 4'd0)
                        state <= GAP;
                    else
                        occ <= occ - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign runway_busy = state != IDLE;
    assign sched_state = state;
endmodule

// File: tb/tb_runway_scheduler.sv
// tb_runway_scheduler: scoreboard bench; expected grants (kind, id, edge number) queued with stimulus.
module tb_runway_scheduler;
    logic       CLK = 1'b0, RST = 1'b0;
    logic       land_req = 1'b0, takeoff_req = 1'b0;
    logic [3:0] land_id = 4'd0, takeoff_id = 4'd0;
    logic       severe_weather = 1'b0, emergency_landing_alert = 1'b0;
    logic       grant_valid, grant_is_land, runway_busy, land_drop, takeoff_drop;
    logic [3:0] grant_id, land_count, takeoff_count;
    logic [1:0] sched_state;

    typedef struct packed {logic il; logic [3:0] id; logic [31:0] cy;} g_t;
    g_t exp_q[$], obs_q[$];
    int total = 0, bad = 0, cyc = 0;

    runway_scheduler #(.QDEPTH(4), .OCC_CYCLES(4)) dut (
        .CLK(CLK), .RST(RST), .land_req(land_req), .land_id(land_id),
        .takeoff_req(takeoff_req), .takeoff_id(takeoff_id),
        .severe_weather(severe_weather), .emergency_landing_alert(emergency_landing_alert),
        .grant_valid(grant_valid), .grant_id(grant_id), .grant_is_land(grant_is_land),
        .runway_busy(runway_busy), .land_count(land_count), .takeoff_count(takeoff_count),
        .land_drop(land_drop), .takeoff_drop(takeoff_drop), .sched_state(sched_state)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) if (RST && grant_valid) obs_q.push_back({grant_is_land, grant_id, 32'(cyc)});

    // Inputs are presented after an edge and sampled on the following edge; returns at edge+1.
    task automatic push(input logic l, input logic [3:0] li, input logic t, input logic [3:0] ti);
        land_req = l; land_id = li; takeoff_req = t; takeoff_id = ti;
        @(posedge CLK); #1;
        land_req = 0; takeoff_req = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_grants(input int n);
        for (int t = 0; t < 300 && obs_q.size() < n; t++) idle(1);
    endtask

    task automatic test_reset;
        idle(2);
        total++; if (sched_state !== 2'b00) begin bad++; $display("FAIL reset_state got=%0d want=0", sched_state); end
        total++; if (land_count !== 4'd0 || takeoff_count !== 4'd0) begin bad++; $display("FAIL reset_counts got=%0d/%0d want=0/0", land_count, takeoff_count); end
        total++; if (runway_busy !== 1'b0 || grant_valid !== 1'b0) begin bad++; $display("FAIL reset_busy_gv got=%b%b want=00", runway_busy, grant_valid); end
        total++; if (grant_id !== 4'd0 || grant_is_land !== 1'b0) begin bad++; $display("FAIL reset_grant got=%0d/%b want=0/0", grant_id, grant_is_land); end
        total++; if (land_drop !== 1'b0 || takeoff_drop !== 1'b0) begin bad++; $display("FAIL reset_drop got=%b%b want=00", land_drop, takeoff_drop); end
        RST = 1'b1;
        idle(2);
    endtask

    task automatic test_land_basic;
        int b = 0;
        g_t e, o;
        push(1, 5, 0, 0);
        exp_q.push_back({1'b1, 4'd5, 32'(cyc + 1)});
        repeat (10) @(negedge CLK) if (runway_busy) b++;
        @(posedge CLK); #1;
        total++; if (b != 5) begin bad++; $display("FAIL land_busy_cycles got=%0d want=5", b); end
        wait_grants(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL land_grant got=none want=%0h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL land_grant got=%0h want=%0h", o, e); end end
        end
        total++; if (land_count !== 4'd0 || sched_state !== 2'b00) begin bad++; $display("FAIL land_after got=%0d/%0d want=0/0", land_count, sched_state); end
    endtask

    task automatic test_weather;
        int b = 0;
        g_t e, o;
        severe_weather = 1;
        push(0, 0, 1, 3);
        idle(20);
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL wx_blocked got=%0d grants want=0", obs_q.size()); end
        total++; if (takeoff_count !== 4'd1 || sched_state !== 2'b00) begin bad++; $display("FAIL wx_queued got=%0d/%0d want=1/0", takeoff_count, sched_state); end
        severe_weather = 0;
        idle(1);
        exp_q.push_back({1'b0, 4'd3, 32'(cyc)});
        severe_weather = 1; emergency_landing_alert = 1;
        repeat (8) @(negedge CLK) if (runway_busy) b++;
        @(posedge CLK); #1;
        severe_weather = 0; emergency_landing_alert = 0;
        total++; if (b != 5) begin bad++; $display("FAIL wx_no_abort got=%0d want=5", b); end
        wait_grants(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL wx_grant got=none want=%0h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL wx_grant got=%0h want=%0h", o, e); end end
        end
        idle(4);
    endtask

    task automatic test_drop;
        int te;
        g_t e, o;
        push(0, 0, 1, 7);
        te = cyc;
        exp_q.push_back({1'b0, 4'd7, 32'(te + 1)});
        for (int i = 1; i <= 5; i++) begin
            push(1, 4'(i), 0, 0);
            @(negedge CLK);
            total++; if (land_drop !== (i == 5)) begin bad++; $display("FAIL drop_pulse_%0d got=%b want=%b", i, land_drop, i == 5); end
            total++; if (land_count !== 4'(i < 4 ? i : 4)) begin bad++; $display("FAIL drop_count_%0d got=%0d want=%0d", i, land_count, i < 4 ? i : 4); end
        end
        @(posedge CLK); #1;
        for (int i = 1; i <= 4; i++) exp_q.push_back({1'b1, 4'(i), 32'(te + 1 + 6 * i)});
        wait_grants(5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL drop_grant got=none want=%0h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL drop_grant got=%0h want=%0h", o, e); end end
        end
        idle(8);
        total++; if (obs_q.size() != 0 || land_count !== 4'd0) begin bad++; $display("FAIL drop_extra got=%0d/%0d want=0/0", obs_q.size(), land_count); end
    endtask

    task automatic test_priority;
        int q;
        g_t e, o;
        push(1, 9, 1, 10);
        exp_q.push_back({1'b1, 4'd9, 32'(cyc + 1)});
        exp_q.push_back({1'b0, 4'd10, 32'(cyc + 7)});
        wait_grants(2);
        idle(8);
        push(1, 1, 1, 2);
        q = cyc;
        push(1, 3, 0, 0);
        push(1, 4, 0, 0);
        push(1, 5, 0, 0);
        exp_q.push_back({1'b1, 4'd1, 32'(q + 1)});
        exp_q.push_back({1'b1, 4'd3, 32'(q + 7)});
        exp_q.push_back({1'b1, 4'd4, 32'(q + 13)});
`ifdef RUNWAY_FAIRNESS_EN
        exp_q.push_back({1'b0, 4'd2, 32'(q + 19)});
        exp_q.push_back({1'b1, 4'd5, 32'(q + 25)});
`else
        exp_q.push_back({1'b1, 4'd5, 32'(q + 19)});
        exp_q.push_back({1'b0, 4'd2, 32'(q + 25)});
`endif
        wait_grants(7);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL prio_grant got=none want=%0h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL prio_grant got=%0h want=%0h", o, e); end end
        end
        idle(8);
`ifdef RUNWAY_FAIRNESS_EN
        emergency_landing_alert = 1;
        push(1, 1, 1, 2);
        q = cyc;
        push(1, 3, 0, 0);
        push(1, 4, 0, 0);
        push(1, 5, 0, 0);
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 4'(i == 0 ? 1 : i + 2), 32'(q + 1 + 6 * i)});
        wait_grants(4);
        idle(12);
        total++; if (obs_q.size() != 4 || takeoff_count !== 4'd1) begin bad++; $display("FAIL ela_hold got=%0d/%0d want=4/1", obs_q.size(), takeoff_count); end
        emergency_landing_alert = 0;
        idle(1);
        exp_q.push_back({1'b0, 4'd2, 32'(cyc)});
        wait_grants(5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL ela_grant got=none want=%0h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL ela_grant got=%0h want=%0h", o, e); end end
        end
        idle(8);
`endif
    endtask

    task automatic test_reset_mid;
        g_t o;
        push(1, 6, 0, 0);
        push(1, 7, 0, 0);
        push(1, 8, 0, 0);
        total++; if (sched_state !== 2'b01 || land_count !== 4'd2) begin bad++; $display("FAIL mid_pre got=%0d/%0d want=1/2", sched_state, land_count); end
        total++;
        if (obs_q.size() != 1) begin bad++; $display("FAIL mid_grant got=%0d grants want=1", obs_q.size()); end
        else begin o = obs_q.pop_front(); if (o.id !== 4'd6 || o.il !== 1'b1) begin bad++; $display("FAIL mid_grant got=%0h want=id 6 land", o); end end
        #2 RST = 1'b0;
        #1;
        total++; if (sched_state !== 2'b00 || runway_busy !== 1'b0) begin bad++; $display("FAIL mid_async got=%0d/%b want=0/0", sched_state, runway_busy); end
        total++; if (land_count !== 4'd0 || takeoff_count !== 4'd0 || grant_id !== 4'd0) begin bad++; $display("FAIL mid_clear got=%0d/%0d/%0d want=0/0/0", land_count, takeoff_count, grant_id); end
        land_req = 1; land_id = 4'd9; takeoff_req = 1;
        idle(3);
        land_req = 0; takeoff_req = 0;
        RST = 1'b1;
        idle(10);
        total++; if (obs_q.size() != 0 || land_count !== 4'd0 || takeoff_count !== 4'd0) begin bad++; $display("FAIL mid_ignored got=%0d/%0d/%0d want=0/0/0", obs_q.size(), land_count, takeoff_count); end
    endtask

    initial begin
        test_reset;
        test_land_basic;
        test_weather;
        test_drop;
        test_priority;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
